mc_program_loader: RTL and testbench
====================================

Name: mc_program_loader

Overview:
- Configuration sequencer for the MC14500B wrapper; drives the wrapper's program-write port and the CPU reset.
- On request, halts the CPU and clears program memory to CLEAR_WORD.
- Then streams in a new program through a valid/ready interface, holds the CPU in reset for a fixed period, and releases it to run from address 0.

Parameters:
- ADDR_WIDTH, 8, program memory address width; depth = 2**ADDR_WIDTH.
- CMD_WIDTH, 12, program word width (4-bit opcode + 8-bit I/O address).
- CLEAR_WORD, 0, word written to every location during clear (NOP encoding).
- RESET_HOLD, 4, cycles cpu_reset stays high after the load completes (min 1).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to begin a reload; ignored unless state is IDLE.
- s_valid  in  1  program word valid.
- s_ready  out  1  loader accepts s_data this cycle.
- s_data  in  CMD_WIDTH  program word.
- s_last  in  1  marks the final word of the program.
- prog_we  out  1  program memory write strobe (wrapper program_write).
- prog_addr  out  ADDR_WIDTH  write address.
- prog_data  out  CMD_WIDTH  write data (wrapper program_cmd).
- cpu_reset  out  1  holds the MC14500B core in reset.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse on return to IDLE after a load.
- overflow  out  1  sticky: program exceeded memory depth; cleared by the next start.
- prog_len  out  ADDR_WIDTH+1  number of words written by the last load.

Behaviour:
- Reset values:
  - state = IDLE, prog_valid = 0.
  - cpu_reset = 1; s_ready, prog_we, busy, done, overflow = 0.
  - prog_addr, prog_data, prog_len = 0.
- Decode: cpu_reset = (state != IDLE) | ~prog_valid. The CPU stays halted after reset until the first completed load.
- All outputs except cpu_reset, busy and s_ready are registered. s_ready is high only in LOAD.
- IDLE:
  - start=1 -> CLEAR; address counter = 0; overflow = 0; prog_valid = 0.
- CLEAR:
  - Each cycle: prog_we=1, prog_addr=counter, prog_data=CLEAR_WORD, then counter++.
  - After writing address 2**ADDR_WIDTH-1 -> LOAD with counter = 0.
  - Takes exactly 2**ADDR_WIDTH cycles.
- LOAD:
  - Handshake: a word transfers when s_valid & s_ready.
  - Registered write: a word accepted in cycle N appears as prog_we=1, prog_addr=counter, prog_data=s_data in cycle N+1. Then counter++.
  - No transfer in a cycle -> prog_we=0 next cycle.
  - s_valid is allowed to drop between words; the loader waits indefinitely.
  - Accepted word with s_last=1 -> HOLD; prog_len = counter+1.
  - Accepted word at address 2**ADDR_WIDTH-1 with s_last=0: write it, set overflow=1, prog_len = 2**ADDR_WIDTH, go to HOLD. The remaining stream is not accepted; s_ready=0 from then on.
- HOLD:
  - cpu_reset=1 for RESET_HOLD cycles (down-counter), s_ready=0, then -> IDLE.
  - On entering IDLE: prog_valid=1, done=1 for one cycle.
- Simultaneous events and boundaries:
  - start while busy: ignored. overflow is not cleared.
  - s_valid outside LOAD: ignored; s_ready=0.
  - Single-word program (s_last on the first word): prog_len = 1.
  - Overflow still releases the CPU; the truncated program runs.
- Reset mid-operation:
  - Any state -> IDLE next cycle, prog_valid=0, so cpu_reset=1.
  - No further writes occur. Memory contents are unspecified but the CPU remains halted.
- Widths: prog_len is ADDR_WIDTH+1 bits so a full-depth program (256 at default) is representable. The address counter wraps only through state exit, never silently.

Test Plan:
- Reset behaviour: apply reset for 2 cycles -> cpu_reset=1, busy=0, prog_we=0, done=0; cpu_reset stays 1 for 20 idle cycles.
- Clear, ADDR_WIDTH=4: pulse start -> exactly 16 consecutive writes of CLEAR_WORD to addresses 0..15. s_ready rises on the cycle after the write to address 15.
- Streamed load with gaps: send 0xA01, 0xB02, 0xC03 (last), with a 2-cycle s_valid gap after the first word.
  - Writes at addresses 0, 1, 2, each one cycle after acceptance.
  - prog_len=3; cpu_reset high for 4 cycles after the final write; done pulses; then cpu_reset=0.
  - The wrapper executes the new program and output_pins match the expected value.
- Overflow, ADDR_WIDTH=4: stream 20 words with no s_last.
  - 16 words accepted; s_ready=0 after the 16th; overflow=1; prog_len=16; CPU released.
  - Next start clears overflow.
- start during LOAD, plus a single-word program: start pulse mid-load has no effect. Then reload with one word (last=1) -> prog_len=1, done pulse.
- Reset mid-LOAD: assert reset after 2 of 5 words -> state IDLE, cpu_reset=1, no further prog_we. A subsequent full load completes normally.

Source files
------------

// File: rtl/mc_program_loader.sv
// Program loader for the MC14500B wrapper: halts the core, clears program memory,
// streams a new program in over valid/ready, then releases the core after a reset hold.
module mc_program_loader #(
   parameter int                        ADDR_WIDTH = 8,
   parameter int                        CMD_WIDTH  = 12,
   parameter logic [CMD_WIDTH-1:0]      CLEAR_WORD = '0,
   parameter int                        RESET_HOLD = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic                  s_valid,
   output logic                  s_ready,
   input  logic [CMD_WIDTH-1:0]  s_data,
   input  logic                  s_last,
   output logic                  prog_we,
   output logic [ADDR_WIDTH-1:0] prog_addr,
   output logic [CMD_WIDTH-1:0]  prog_data,
   output logic                  cpu_reset,
   output logic                  busy,
   output logic                  done,
   output logic                  overflow,
   output logic [ADDR_WIDTH:0]   prog_len
);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_CLEAR = 2'd1;
   localparam logic [1:0] ST_LOAD  = 2'd2;
   localparam logic [1:0] ST_HOLD  = 2'd3;

   localparam int                    HOLD_W    = $clog2(RESET_HOLD + 1);
   localparam logic [HOLD_W-1:0]     HOLD_INIT = HOLD_W'(RESET_HOLD - 1);
   localparam logic [ADDR_WIDTH-1:0] ADDR_MAX  = '1;

   logic [1:0]            state_q, state_d;
   logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
   logic [HOLD_W-1:0]     hold_q, hold_d;
   logic                  prog_valid_q, prog_valid_d;
   logic                  prog_we_q, prog_we_d;
   logic [ADDR_WIDTH-1:0] prog_addr_q, prog_addr_d;
   logic [CMD_WIDTH-1:0]  prog_data_q, prog_data_d;
   logic                  done_q, done_d;
   logic                  overflow_q, overflow_d;
   logic [ADDR_WIDTH:0]   prog_len_q, prog_len_d;
   logic                  accept;

   assign s_ready   = (state_q == ST_LOAD);
   assign accept    = s_valid & s_ready;
   assign busy      = (state_q != ST_IDLE);
   // Core stays halted from power-up until the first load has completed.
   assign cpu_reset = busy | ~prog_valid_q;

   assign prog_we   = prog_we_q;
   assign prog_addr = prog_addr_q;
   assign prog_data = prog_data_q;
   assign done      = done_q;
   assign overflow  = overflow_q;
   assign prog_len  = prog_len_q;

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      hold_d       = hold_q;
      prog_valid_d = prog_valid_q;
      prog_we_d    = 1'b0;
      prog_addr_d  = prog_addr_q;
      prog_data_d  = prog_data_q;
      done_d       = 1'b0;
      overflow_d   = overflow_q;
      prog_len_d   = prog_len_q;

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               // The first clear write is issued alongside the state change so that
               // the write strobe lines up with the CLEAR cycles themselves.
               state_d      = ST_CLEAR;
               cnt_d        = '0;
               overflow_d   = 1'b0;
               prog_valid_d = 1'b0;
               prog_we_d    = 1'b1;
               prog_addr_d  = '0;
               prog_data_d  = CLEAR_WORD;
            end
         end
         ST_CLEAR: begin
            if (cnt_q == ADDR_MAX) begin
               state_d = ST_LOAD;
               cnt_d   = '0;
            end else begin
               cnt_d       = cnt_q + ADDR_WIDTH'(1);
               prog_we_d   = 1'b1;
               prog_addr_d = cnt_q + ADDR_WIDTH'(1);
               prog_data_d = CLEAR_WORD;
            end
         end
         ST_LOAD: begin
            if (accept) begin
               prog_we_d   = 1'b1;
               prog_addr_d = cnt_q;
               prog_data_d = s_data;
               cnt_d       = cnt_q + ADDR_WIDTH'(1);
               if (s_last || (cnt_q == ADDR_MAX)) begin
                  // Extra bit in prog_len keeps a full-depth program representable.
                  state_d    = ST_HOLD;
                  hold_d     = HOLD_INIT;
                  cnt_d      = '0;
                  prog_len_d = {1'b0, cnt_q} + (ADDR_WIDTH + 1)'(1);
                  if (!s_last) begin
                     overflow_d = 1'b1;
                  end
               end
            end
         end
         default: begin
            if (hold_q == '0) begin
               state_d      = ST_IDLE;
               prog_valid_d = 1'b1;
               done_d       = 1'b1;
            end else begin
               hold_d = hold_q - HOLD_W'(1);
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         cnt_q        <= '0;
         hold_q       <= '0;
         prog_valid_q <= 1'b0;
         prog_we_q    <= 1'b0;
         prog_addr_q  <= '0;
         prog_data_q  <= '0;
         done_q       <= 1'b0;
         overflow_q   <= 1'b0;
         prog_len_q   <= '0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         hold_q       <= hold_d;
         prog_valid_q <= prog_valid_d;
         prog_we_q    <= prog_we_d;
         prog_addr_q  <= prog_addr_d;
         prog_data_q  <= prog_data_d;
         done_q       <= done_d;
         overflow_q   <= overflow_d;
         prog_len_q   <= prog_len_d;
      end
   end

endmodule

// File: tb/tb_mc_program_loader.sv
// Self-checking bench for mc_program_loader: randomized program streams checked against
// a memory-image and transaction-level model of the reload sequence.
module tb_mc_program_loader;

   localparam int              AW    = 4;
   localparam int              CW    = 12;
   localparam int              DEPTH = 1 << AW;
   localparam int              RH    = 4;
   localparam logic [CW-1:0]   CLR   = 12'h5A5;

   logic          clk = 1'b0;
   logic          reset, start, s_valid, s_ready, s_last;
   logic [CW-1:0] s_data, prog_data;
   logic          prog_we, cpu_reset, busy, done, overflow;
   logic [AW-1:0] prog_addr;
   logic [AW:0]   prog_len;

   int checks = 0;
   int errors = 0;

   logic [CW-1:0] tb_mem [DEPTH];
   logic [CW-1:0] words  [DEPTH + 8];

   always #5 clk = ~clk;

   mc_program_loader #(
      .ADDR_WIDTH (AW),
      .CMD_WIDTH  (CW),
      .CLEAR_WORD (CLR),
      .RESET_HOLD (RH)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .s_valid   (s_valid),
      .s_ready   (s_ready),
      .s_data    (s_data),
      .s_last    (s_last),
      .prog_we   (prog_we),
      .prog_addr (prog_addr),
      .prog_data (prog_data),
      .cpu_reset (cpu_reset),
      .busy      (busy),
      .done      (done),
      .overflow  (overflow),
      .prog_len  (prog_len)
   );

   // Memory image as the wrapper would see it.
   always @(negedge clk) begin
      if (prog_we) tb_mem[prog_addr] <= prog_data;
   end

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic check_image(input int n);
      for (int i = 0; i < DEPTH; i++) begin
         check_eq("image", tb_mem[i], (i < n) ? words[i] : CLR);
      end
   endtask

   // Called and returns on a negedge. start_at / abort_at < 0 disable those events.
   task automatic run_load(input int n, input bit has_last, input int max_gap,
                           input int first_gap, input int start_at, input int abort_at);
      int            acc, idx, gap, cyc, exp_len;
      bit            pend, ended, start_done, exp_ovf;
      logic [AW-1:0] pa;
      logic [CW-1:0] pd;
      acc = 0; idx = 0; cyc = 0; exp_len = 0;
      pend = 0; ended = 0; start_done = 0; exp_ovf = 0;
      pa = '0; pd = '0;

      start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         s_valid = 1'($urandom); s_data = CW'($urandom); s_last = 1'($urandom);
         check_eq("clear", {prog_we, prog_addr, prog_data, s_ready, overflow, busy, cpu_reset},
                  {1'b1, AW'(i), CLR, 1'b0, 1'b0, 1'b1, 1'b1});
         @(negedge clk);
      end

      gap = $urandom_range(0, max_gap);
      forever begin
         if (pend) check_eq("write", {prog_we, prog_addr, prog_data}, {1'b1, pa, pd});
         else      check_eq("no_write", prog_we, 1'b0);
         check_eq("s_ready", s_ready, !ended);
         check_eq("load_flags", {busy, cpu_reset, done}, 3'b110);
         pend = 0;
         if (ended) break;
         if (acc == abort_at) begin
            reset = 1'b1; s_valid = 1'b0;
            @(posedge clk);
            @(negedge clk);
            reset = 1'b0;
            for (int i = 0; i < 6; i++) begin
               check_eq("abort_idle", {busy, cpu_reset, done, prog_we, s_ready}, 5'b01000);
               check_eq("abort_regs", {prog_len, overflow}, 0);
               s_valid = 1'b1; s_data = CW'($urandom); s_last = 1'($urandom);
               @(negedge clk);
            end
            s_valid = 1'b0;
            check_image(acc);
            $display("load n=%0d aborted by reset after %0d words", n, acc);
            return;
         end
         cyc++;
         if (cyc > 1000) begin
            check_eq("load_timeout", cyc, 0);
            return;
         end
         start = (start_at >= 0) && (idx == start_at) && !start_done;
         if (start) start_done = 1;
         if (gap > 0) begin
            gap--;
            s_valid = 1'b0; s_data = CW'($urandom); s_last = 1'($urandom);
         end else if (idx < n) begin
            s_valid = 1'b1; s_data = words[idx]; s_last = has_last && (idx == n - 1);
         end else begin
            s_valid = 1'b0;
         end
         @(posedge clk);
         if (s_valid && !ended) begin
            pend = 1; pa = AW'(acc); pd = s_data; acc++;
            if (s_last || acc == DEPTH) begin
               ended   = 1;
               exp_len = acc;
               exp_ovf = !s_last;
            end
            idx++;
            gap = (idx == 1) ? first_gap : int'($urandom_range(0, max_gap));
         end
         @(negedge clk);
         start = 1'b0;
      end

      for (int h = 0; h < RH; h++) begin
         check_eq("hold", {busy, cpu_reset, done, s_ready}, 4'b1100);
         if (h > 0) check_eq("hold_no_write", prog_we, 1'b0);
         s_valid = 1'($urandom); s_data = CW'($urandom); s_last = 1'($urandom);
         @(negedge clk);
      end
      check_eq("done", {busy, cpu_reset, done, prog_we}, 4'b0010);
      check_eq("prog_len", prog_len, exp_len);
      check_eq("overflow", overflow, exp_ovf);
      s_valid = 1'b0;
      @(negedge clk);
      check_eq("idle", {busy, cpu_reset, done, s_ready}, 4'b0000);
      check_eq("overflow_sticky", overflow, exp_ovf);
      check_image(exp_len);
      $display("load n=%0d last=%0d -> prog_len=%0d overflow=%0d", n, has_last, prog_len, overflow);
   endtask

   task automatic fill_random(input int n);
      for (int i = 0; i < n; i++) words[i] = CW'($urandom);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int  n;
      bit  last;
      reset = 1'b1; start = 1'b0; s_valid = 1'b0; s_data = '0; s_last = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_eq("reset_flags", {cpu_reset, busy, prog_we, done, s_ready, overflow}, 6'b100000);
      check_eq("reset_regs", {prog_addr, prog_data, prog_len}, 0);
      reset = 1'b0;
      for (int i = 0; i < 20; i++) begin
         s_valid = 1'($urandom); s_data = CW'($urandom); s_last = 1'($urandom);
         @(negedge clk);
         check_eq("post_reset_idle", {cpu_reset, busy, prog_we, done, s_ready}, 5'b10000);
      end
      s_valid = 1'b0;

      words[0] = 12'hA01; words[1] = 12'hB02; words[2] = 12'hC03;
      run_load(3, 1'b1, 0, 2, -1, -1);

      fill_random(20);
      run_load(20, 1'b0, 1, 1, -1, -1);

      fill_random(5);
      run_load(5, 1'b1, 1, 0, 2, -1);

      fill_random(1);
      run_load(1, 1'b1, 0, 0, -1, -1);

      fill_random(5);
      run_load(5, 1'b1, 1, 0, -1, 2);

      fill_random(5);
      run_load(5, 1'b1, 0, 1, -1, -1);

      fill_random(DEPTH);
      run_load(DEPTH, 1'b1, 0, 0, -1, -1);

      for (int t = 0; t < 6; t++) begin
         n = $urandom_range(1, DEPTH + 4);
         if (n < DEPTH)       last = 1'b1;
         else if (n == DEPTH) last = 1'($urandom);
         else                 last = 1'b0;
         fill_random(n);
         run_load(n, last, 2, $urandom_range(0, 2), -1, -1);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
